wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 81 ++++++++
 tb/tb_wb_arbiter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter: picks one of NUM_REQ requesters per cycle and
// registers the winner as a register-file write, suppressing writes to x0.
module wb_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          flush_in,
  input  logic [NUM_REQ-1:0]            req_valid_in,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_in,
  output logic [NUM_REQ-1:0]            req_ready_out,
  output logic                          we_out,
  output logic [ADDR_WIDTH-1:0]         wa_out,
  output logic [DATA_WIDTH-1:0]         wd_out,
  output logic [15:0]                   conflict_count_out
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]         ptr;
  logic [PW-1:0]         gidx;
  logic                  found;
  logic                  grant;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  conflict;

  // Rotating priority: first scan indices at or above ptr, then wrap to below it.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid_in[i] && i >= int'(ptr)) begin
        found = 1'b1;
        gidx  = PW'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid_in[i] && i < int'(ptr)) begin
        found = 1'b1;
        gidx  = PW'(i);
      end
    end
  end

  always_comb begin
    grant         = found && !flush_in && !rst_in;
    req_ready_out = '0;
    if (grant) req_ready_out[gidx] = 1'b1;
  end

  assign sel_addr = req_addr_in[int'(gidx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_data = req_data_in[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
  assign conflict = $countones(req_valid_in) > 1;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ptr                <= '0;
      we_out             <= 1'b0;
      wa_out             <= '0;
      wd_out             <= '0;
      conflict_count_out <= '0;
    end else begin
      if (grant) begin
        ptr    <= (gidx == PW'(NUM_REQ-1)) ? '0 : gidx + PW'(1);
        wa_out <= sel_addr;
        wd_out <= sel_data;
        we_out <= |sel_addr;
      end else begin
        we_out <= 1'b0;
      end
      // Conflicts are counted even while flushing.
      if (conflict && conflict_count_out != 16'hFFFF)
        conflict_count_out <= conflict_count_out + 16'd1;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: vector table plus hand sequences for reset, flush and
// counter saturation; registered writes are checked through an expectation queue.
module tb_wb_arbiter;
  localparam int N = 3, DW = 32, AW = 5;

  logic              clk_in = 1'b0;
  logic              rst_in, flush_in;
  logic [N-1:0]      req_valid_in;
  logic [N*AW-1:0]   req_addr_in;
  logic [N*DW-1:0]   req_data_in;
  logic [N-1:0]      req_ready_out;
  logic              we_out;
  logic [AW-1:0]     wa_out;
  logic [DW-1:0]     wd_out;
  logic [15:0]       conflict_count_out;

  wb_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in),
    .req_valid_in(req_valid_in), .req_addr_in(req_addr_in), .req_data_in(req_data_in),
    .req_ready_out(req_ready_out), .we_out(we_out), .wa_out(wa_out), .wd_out(wd_out),
    .conflict_count_out(conflict_count_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        rst, flush;
    logic [2:0]  valid;
    logic [14:0] addr;
    logic [95:0] data;
    logic [2:0]  ready;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
  } vec_t;

  typedef struct { logic we; logic [4:0] wa; logic [31:0] wd; } exp_t;

  exp_t        exp_q[$];
  vec_t        tbl[$];
  int          tests = 0, fails = 0;
  logic [15:0] cnt_m;

  function automatic vec_t mk(logic rst, logic flush, logic [2:0] v, logic [14:0] a,
                              logic [95:0] d, logic [2:0] r, logic we, logic [4:0] wa,
                              logic [31:0] wd);
    vec_t x;
    x.rst = rst; x.flush = flush; x.valid = v; x.addr = a; x.data = d;
    x.ready = r; x.we = we; x.wa = wa; x.wd = wd;
    return x;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one vector, check combinational ready, then check the registered write.
  task automatic step(input vec_t v, input string tag);
    exp_t e;
    @(negedge clk_in);
    rst_in = v.rst; flush_in = v.flush; req_valid_in = v.valid;
    req_addr_in = v.addr; req_data_in = v.data;
    #1;
    check({tag, ".ready"}, 64'(req_ready_out), 64'(v.ready));
    exp_q.push_back('{v.we, v.wa, v.wd});
    if (v.rst) cnt_m = 16'd0;
    else if ($countones(v.valid) >= 2 && cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
    @(posedge clk_in);
    #1;
    e = exp_q.pop_front();
    check({tag, ".we"}, 64'(we_out), 64'(e.we));
    check({tag, ".wa"}, 64'(wa_out), 64'(e.wa));
    check({tag, ".wd"}, 64'(wd_out), 64'(e.wd));
    check({tag, ".cnt"}, 64'(conflict_count_out), 64'(cnt_m));
  endtask

  localparam logic [14:0] A3 = {5'd3, 5'd2, 5'd1};
  localparam logic [95:0] D3 = {32'hA2, 32'hA1, 32'hA0};

  initial begin
    rst_in = 1'b1; flush_in = 1'b0; req_valid_in = '0; req_addr_in = '0; req_data_in = '0;
    cnt_m = 16'd0;

    // Reset with every requester valid: nothing granted, all outputs zero.
    step(mk(1, 0, 3'b111, A3, D3, 3'b000, 0, 5'd0, 32'h0), "rst0");
    step(mk(1, 1, 3'b111, A3, D3, 3'b000, 0, 5'd0, 32'h0), "rst1");

    // All three held valid out of reset: grant order 0,1,2,0.
    step(mk(0, 0, 3'b111, A3, D3, 3'b001, 1, 5'd1, 32'hA0), "rr0");
    step(mk(0, 0, 3'b111, A3, D3, 3'b010, 1, 5'd2, 32'hA1), "rr1");
    step(mk(0, 0, 3'b111, A3, D3, 3'b100, 1, 5'd3, 32'hA2), "rr2");
    step(mk(0, 0, 3'b111, A3, D3, 3'b001, 1, 5'd1, 32'hA0), "rr3");
    step(mk(1, 0, 3'b000, A3, D3, 3'b000, 0, 5'd0, 32'h0),  "rst2");

    tbl.push_back(mk(0, 0, 3'b010, {5'd0, 5'd5, 5'd0}, {32'h0, 32'hDEADBEEF, 32'h0},
                     3'b010, 1, 5'd5, 32'hDEADBEEF));
    tbl.push_back(mk(0, 0, 3'b111, A3, D3, 3'b100, 1, 5'd3, 32'hA2));
    tbl.push_back(mk(0, 0, 3'b111, A3, D3, 3'b001, 1, 5'd1, 32'hA0));
    tbl.push_back(mk(0, 0, 3'b111, A3, D3, 3'b010, 1, 5'd2, 32'hA1));
    tbl.push_back(mk(0, 0, 3'b111, A3, D3, 3'b100, 1, 5'd3, 32'hA2));
    tbl.push_back(mk(0, 0, 3'b111, A3, D3, 3'b001, 1, 5'd1, 32'hA0));
    tbl.push_back(mk(0, 0, 3'b001, 15'd0, {32'h0, 32'h0, 32'h7}, 3'b001, 0, 5'd0, 32'h7));
    tbl.push_back(mk(0, 0, 3'b000, 15'd0, 96'h0, 3'b000, 0, 5'd0, 32'h7));
    tbl.push_back(mk(0, 1, 3'b100, {5'd9, 5'd0, 5'd0}, {32'h99, 64'h0}, 3'b000, 0, 5'd0, 32'h7));
    tbl.push_back(mk(0, 1, 3'b100, {5'd9, 5'd0, 5'd0}, {32'h99, 64'h0}, 3'b000, 0, 5'd0, 32'h7));
    tbl.push_back(mk(0, 0, 3'b100, {5'd9, 5'd0, 5'd0}, {32'h99, 64'h0}, 3'b100, 1, 5'd9, 32'h99));
    tbl.push_back(mk(0, 0, 3'b110, {5'd9, 5'd4, 5'd0}, {32'h99, 32'h44, 32'h0}, 3'b010, 1, 5'd4, 32'h44));
    tbl.push_back(mk(0, 0, 3'b011, {5'd0, 5'd4, 5'd6}, {32'h0, 32'h44, 32'h66}, 3'b001, 1, 5'd6, 32'h66));
    tbl.push_back(mk(0, 0, 3'b011, {5'd0, 5'd4, 5'd6}, {32'h0, 32'h44, 32'h66}, 3'b010, 1, 5'd4, 32'h44));
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("t%0d", i));

    // Reset lands on a cycle that would grant req 1; search restarts at 0 afterwards.
    step(mk(0, 0, 3'b001, {5'd0, 5'd4, 5'd6}, {32'h0, 32'h44, 32'h66}, 3'b001, 1, 5'd6, 32'h66), "mr0");
    step(mk(1, 0, 3'b010, {5'd0, 5'd4, 5'd6}, {32'h0, 32'h44, 32'h66}, 3'b000, 0, 5'd0, 32'h0), "mr1");
    step(mk(0, 0, 3'b011, {5'd0, 5'd4, 5'd6}, {32'h0, 32'h44, 32'h66}, 3'b001, 1, 5'd6, 32'h66), "mr2");

    // Saturation: conflicts counted under flush, with grants blocked throughout.
    step(mk(1, 0, 3'b000, 15'd0, 96'h0, 3'b000, 0, 5'd0, 32'h0), "rst3");
    @(negedge clk_in);
    rst_in = 1'b0; flush_in = 1'b1; req_valid_in = 3'b111; req_addr_in = A3; req_data_in = D3;
    #1 check("sat.ready", 64'(req_ready_out), 64'h0);
    repeat (65534) @(posedge clk_in);
    #1 check("sat.fffe", 64'(conflict_count_out), 64'hFFFE);
    @(posedge clk_in);
    #1 check("sat.ffff", 64'(conflict_count_out), 64'hFFFF);
    repeat (5) @(posedge clk_in);
    #1 check("sat.hold", 64'(conflict_count_out), 64'hFFFF);
    check("sat.we", 64'(we_out), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end
endmodule
